// File: rtl/output_fifo.sv
// output_fifo: DEPTH-entry result buffer draining to a registered valid/ready stream with burst marking
module output_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_last,
    output logic                     idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [BW-1:0]    beat;
    logic             empty, wr_ok, load, hs;

    // status is derived from registers only, so downstream sees no comb path from wr_en/m_ready
    always_comb begin
        empty  = wr_ptr == rd_ptr;
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        count  = wr_ptr - rd_ptr;
        wr_ok  = wr_en && !full;
        hs     = m_valid && m_ready;
        load   = !empty && (!m_valid || m_ready);
        idle   = empty && !m_valid;
        m_last = m_valid && (beat == LAST_BEAT);
    end

    // storage array is not reset; a flush discards the concurrent write
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // pointers, output register, burst counter and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat     <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat     <= '0;
            m_valid  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en && full) overflow <= 1'b1;
            if (hs) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
            if (load) begin
                m_data  <= mem[rd_ptr[AW-1:0]];
                m_valid <= 1'b1;
                rd_ptr  <= rd_ptr + 1'b1;
            end else if (hs) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_output_fifo.sv
// tb_output_fifo: scoreboard bench for output_fifo (ordering, latency, stall, burst marking, flush, reset)
module tb_output_fifo;
    localparam int DEPTH     = 16;
    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic                   wr_en = 1'b0;
    logic [WIDTH-1:0]       wr_data = '0;
    logic                   m_ready = 1'b0;
    logic                   full, overflow, m_valid, m_last, idle;
    logic [$clog2(DEPTH):0] count;
    logic [WIDTH-1:0]       m_data;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;
    int tb_beat = 0;
    logic signed [WIDTH-1:0] q[$];

    output_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .overflow(overflow), .count(count), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic signed [WIDTH-1:0] v, input bit accept);
        wr_en = 1'b1;
        wr_data = v;
        if (accept) q.push_back(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        q.delete();
        tb_beat = 0;
        tick();
        flush = 1'b0;
        check("flush_valid", m_valid, 0);
        check("flush_count", count, 0);
        check("flush_ovf", overflow, 0);
    endtask

    task automatic drain();
        int i = 0;
        m_ready = 1'b1;
        while ((q.size() != 0 || m_valid) && i < 200) begin
            tick();
            i++;
        end
        check("drained", q.size(), 0);
        check("idle", idle, 1);
    endtask

    // output monitor: sampled on the falling edge, pops the scoreboard when a handshake is pending
    always @(negedge clk) begin
        if (rst && !flush) begin
            if (m_valid) begin
                check("occupied", q.size() > 0, 1);
                if (q.size() > 0) check("data", $signed(m_data), q[0]);
                check("last", m_last, tb_beat == BURST_LEN - 1);
                if (m_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    tb_beat = (tb_beat == BURST_LEN - 1) ? 0 : tb_beat + 1;
                    n_hs++;
                end
            end else begin
                check("last_idle", m_last, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int i;
        tick();
        tick();
        check("rst_idle", idle, 1);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_last", m_last, 0);
        rst = 1'b1;
        tick();

        // back-to-back writes with one-edge write-to-output latency
        m_ready = 1'b1;
        wr(1, 1);
        check("lat0_valid", m_valid, 0);
        wr(2, 1);
        check("lat1_data", m_data, 1);
        wr(3, 1);
        check("lat2_data", m_data, 2);
        tick();
        check("lat3_data", m_data, 3);
        tick();
        check("after_idle", idle, 1);
        drain();

        // fill array plus output register, then overflow
        do_flush();
        m_ready = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            wr(k, 1);
            check("fill_count", count, k == 0 ? 1 : k);
            check("fill_full", full, k == 16);
            check("fill_ovf", overflow, 0);
        end
        check("fill_head", m_data, 0);
        wr(17, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        drain();
        check("ovf_sticky", overflow, 1);

        // stall holds a signed beat stable
        do_flush();
        m_ready = 1'b1;
        wr(-5, 1);
        wr(-6, 1);
        wr(-7, 1);
        m_ready = 1'b0;
        check("stall0", $signed(m_data), -6);
        tick();
        check("stall1", $signed(m_data), -6);
        tick();
        check("stall2", $signed(m_data), -6);
        check("stall_valid", m_valid, 1);
        drain();

        // burst marking over 10 beats, then async reset mid-burst
        do_flush();
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) wr(100 + k, 1);
        drain();
        do_flush();
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) wr(200 + k, 1);
        n_hs = 0;
        m_ready = 1'b1;
        i = 0;
        while (n_hs < 6 && i < 50) begin
            tick();
            i++;
        end
        check("hs6", n_hs >= 6, 1);
        #2;
        rst = 1'b0;
        q.delete();
        tb_beat = 0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_count", count, 0);
        check("arst_last", m_last, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) wr(300 + k, 1);
        drain();

        // simultaneous write and load keep occupancy constant
        do_flush();
        m_ready = 1'b0;
        for (int k = 0; k < 16; k++) wr(400 + k, 1);
        check("sim_pre", count, 15);
        m_ready = 1'b1;
        wr(500, 1);
        check("sim_count", count, 15);
        check("sim_ovf", overflow, 0);
        drain();

        // flush with concurrent write after overflow
        m_ready = 1'b0;
        for (int k = 0; k < 18; k++) wr(600 + k, k < 17);
        check("pre_flush_ovf", overflow, 1);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 999;
        q.delete();
        tb_beat = 0;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("fl_valid", m_valid, 0);
        check("fl_count", count, 0);
        check("fl_ovf", overflow, 0);
        tick();
        check("fl_discard_valid", m_valid, 0);
        check("fl_discard_count", count, 0);
        check("fl_idle", idle, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
